csa_resolver: RTL and testbench

Converts a carry-save pair (s, c) from the CSA tree blocks into a plain binary sum. It is the carry-propagate end of the adder tree. The block performs a multi-cycle, chunk-serial ripple add with a carry register, trading latency for a short critical path. Valid/ready handshakes on input and output let it sit between a registered CSA stage and downstream consumers.

---
 rtl/csa_resolver_if.sv | 25 ++
 rtl/csa_resolver.sv | 100 ++++++++++
 tb/tb_csa_resolver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/csa_resolver_if.sv
// Handshake bundle between a carry-save producer, the resolver and its consumer.
// The slave modport is the resolver's view; master is the view of the logic driving it.
interface csa_resolver_if #(
  parameter int MAX = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [MAX-1:0] in_s;
  logic [MAX-1:0] in_c;
  logic           out_valid;
  logic           out_ready;
  logic [MAX-1:0] out_sum;
  logic           out_cout;
  logic           busy;

  modport slave (
    input  in_valid, in_s, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );

  modport master (
    output in_valid, in_s, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into a binary sum, CHUNK bits per cycle; latency MAX/CHUNK after accept.
// Single-entry: in_ready is low from accept until the result is taken; result holds while out_ready is low.
module csa_resolver #(
  parameter int MAX   = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  csa_resolver_if.slave bus
);
  localparam int NCHUNK = MAX / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((MAX % CHUNK) != 0) begin : g_bad_chunk
    $error("csa_resolver: CHUNK must divide MAX exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [MAX-1:0]   s_q, s_d;
  logic [MAX-1:0]   c_q, c_d;
  logic             carry_q, carry_d;
  logic [MAX-1:0]   sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [31:0]      base;
  logic [CHUNK:0]   chunk_sum;

  // One ripple slice per cycle keeps the carry path to CHUNK bits.
  assign base      = 32'(idx_q) * 32'(CHUNK);
  assign chunk_sum = {1'b0, s_q[base +: CHUNK]} + {1'b0, c_q[base +: CHUNK]}
                   + (CHUNK+1)'(carry_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s_d     = s_q;
    c_d     = c_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.in_s;
          c_d     = bus.in_c;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d              = chunk_sum[CHUNK];
        idx_d                = idx_q + 1'b1;
        if (idx_q == IDXW'(NCHUNK-1)) begin
          cout_d  = chunk_sum[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ADD) || (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomised checks of csa_resolver (32/8) plus a 7/7 single-cycle instance
// fed from a seven-input carry-save reduction.
module tb_csa_resolver;
  logic clk;
  logic reset;
  int   nchecks = 0;
  int   nerrs   = 0;

  csa_resolver_if #(.MAX(32)) bus ();
  csa_resolver_if #(.MAX(7))  bus7 ();

  csa_resolver #(.MAX(32), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  csa_resolver #(.MAX(7), .CHUNK(7)) dut7 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus7.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a pair, hold it until the edge that accepts it, then drop in_valid.
  task automatic send(input logic [31:0] s, input logic [31:0] c);
    int n;
    bus.in_valid = 1'b1;
    bus.in_s     = s;
    bus.in_c     = c;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    chk("result_timeout", 64'(cyc < 50), 64'd1);
  endtask

  function automatic logic [13:0] csa3(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    logic [6:0] s, k;
    s = a ^ b ^ c;
    k = ((a & b) | (a & c) | (b & c)) << 1;
    return {s, k};
  endfunction

  initial begin
    int          cyc;
    logic [31:0] rs, rc;
    logic [32:0] exp33;
    logic [13:0] r1, r2, r3, r4, r5;
    logic [6:0]  v [7];

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_s = '0; bus.in_c = '0; bus.out_ready = 1'b0;
    bus7.in_valid = 1'b0; bus7.in_s = '0; bus7.in_c = '0; bus7.out_ready = 1'b0;
    step();
    step();
    reset = 1'b1;

    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_out_sum",   64'(bus.out_sum),   64'd0);
    chk("rst_out_cout",  64'(bus.out_cout),  64'd0);

    // Small sum with a carry across the first chunk boundary.
    send(32'h0000_00FF, 32'h0000_0002);
    chk("t1_busy",     64'(bus.busy),     64'd1);
    chk("t1_in_ready", 64'(bus.in_ready), 64'd0);
    wait_out(cyc);
    chk("t1_latency",  64'(cyc),          64'd4);
    chk("t1_sum",      64'(bus.out_sum),  64'h0000_0101);
    chk("t1_cout",     64'(bus.out_cout), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t1_pop_idle", 64'(bus.in_ready), 64'd1);

    // Carry ripples through every chunk and out the top.
    send(32'hFFFF_FFFF, 32'h0000_0002);
    wait_out(cyc);
    chk("t2_latency", 64'(cyc),          64'd4);
    chk("t2_sum",     64'(bus.out_sum),  64'h0000_0001);
    chk("t2_cout",    64'(bus.out_cout), 64'd1);

    // Backpressure: result held, a new pair offered meanwhile is not taken.
    bus.in_valid = 1'b1;
    bus.in_s     = 32'h1111_1111;
    bus.in_c     = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid",    64'(bus.out_valid), 64'd1);
      chk("t3_hold_sum",      64'(bus.out_sum),   64'h0000_0001);
      chk("t3_hold_in_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t3_idle_in_ready",  64'(bus.in_ready),  64'd1);
    chk("t3_idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t3_idle_busy",      64'(bus.busy),      64'd0);
    chk("t3_idle_sum_kept",  64'(bus.out_sum),   64'h0000_0001);
    step();
    chk("t3_not_captured",   64'(bus.busy),      64'd0);

    // Reset lands while chunk index 2 is being resolved.
    send(32'h1234_5678, 32'h0F0F_0F0F);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_busy",      64'(bus.busy),      64'd0);
    chk("t4_in_ready",  64'(bus.in_ready),  64'd1);
    chk("t4_sum",       64'(bus.out_sum),   64'd0);
    chk("t4_cout",      64'(bus.out_cout),  64'd0);
    send(32'd5, 32'd6);
    wait_out(cyc);
    chk("t4_after_sum", 64'(bus.out_sum),  64'd11);
    chk("t4_after_cout", 64'(bus.out_cout), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Stream of pairs with random idle gaps and consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        rs = 32'h0; rc = 32'h0;
      end else if (i == 1) begin
        rs = 32'hFFFF_FFFF; rc = 32'hFFFF_FFFF;
      end else begin
        rs = $urandom; rc = $urandom;
      end
      exp33 = {1'b0, rs} + {1'b0, rc};
      if (i == 1) chk("t5_allones_ref", 64'(exp33), 64'h1_FFFF_FFFE);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
      send(rs, rc);
      bus.in_s = $urandom;
      bus.in_c = $urandom;
      wait_out(cyc);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step();
        chk("t5_stall_valid", 64'(bus.out_valid), 64'd1);
      end
      chk("t5_result", 64'({bus.out_cout, bus.out_sum}), 64'(exp33));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("t5_single_result", 64'(bus.out_valid), 64'd0);
    end

    // Seven 7-bit inputs reduced to carry-save form; sum is 456 mod 128 = 72.
    v[0] = 7'h55; v[1] = 7'h7F; v[2] = 7'h12; v[3] = 7'h40;
    v[4] = 7'h33; v[5] = 7'h01; v[6] = 7'h6E;
    r1 = csa3(v[0], v[1], v[2]);
    r2 = csa3(v[3], v[4], v[5]);
    r3 = csa3(r1[13:7], r1[6:0], r2[13:7]);
    r4 = csa3(r2[6:0], v[6], r3[13:7]);
    r5 = csa3(r3[6:0], r4[13:7], r4[6:0]);
    bus7.in_valid = 1'b1;
    bus7.in_s     = r5[13:7];
    bus7.in_c     = r5[6:0];
    chk("t6_in_ready", 64'(bus7.in_ready), 64'd1);
    step();
    bus7.in_valid = 1'b0;
    chk("t6_busy", 64'(bus7.busy), 64'd1);
    step();
    chk("t6_out_valid", 64'(bus7.out_valid), 64'd1);
    chk("t6_sum",       64'(bus7.out_sum),   64'd72);
    bus7.out_ready = 1'b1;
    step();
    bus7.out_ready = 1'b0;
    chk("t6_idle", 64'(bus7.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
